// File: rtl/wb_stream_loader.sv
// Wishbone master that unpacks a byte stream (6-byte header + big-endian words)
// into single-beat write cycles, reporting completion or ack timeout.
module wb_stream_loader #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    HDR,
    DATA,
    WRITE
  } state_t;

  localparam logic [15:0] TimeoutLast = 16'(timeout_cycles - 1);

  state_t      state_q, state_d;
  logic [2:0]  byte_cnt_q;
  logic [23:0] shift_q;
  logic [31:0] addr_q;
  logic [15:0] count_q;
  logic [15:0] timer_q;
  logic        ready_q;
  logic        cyc_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;

  logic        accept;
  logic        hdr_last;
  logic        data_last;
  logic        ack_hit;
  logic        time_out;
  logic        last_word;
  logic [15:0] hdr_count;

  always_comb begin
    accept    = byte_valid_i && ready_q;
    hdr_last  = (state_q == HDR) && accept && (byte_cnt_q == 3'd5);
    data_last = (state_q == DATA) && accept && (byte_cnt_q == 3'd3);
    hdr_count = {shift_q[7:0], byte_i};
    ack_hit   = (state_q == WRITE) && wb_ack_i;
    // An ack arriving on the timeout edge wins; only a missing ack aborts.
    time_out  = (state_q == WRITE) && !wb_ack_i && (timer_q == TimeoutLast);
    last_word = (count_q == 16'd1);

    state_d = state_q;
    case (state_q)
      HDR: begin
        if (hdr_last) state_d = (hdr_count == 16'd0) ? HDR : DATA;
      end
      DATA: begin
        if (data_last) state_d = WRITE;
      end
      WRITE: begin
        if (ack_hit)       state_d = last_word ? HDR : DATA;
        else if (time_out) state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  // Ready is registered from the next state so it drops on the edge the
  // cycle starts and returns on the ack edge, never overlapping strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= HDR;
      byte_cnt_q <= 3'd0;
      shift_q    <= 24'd0;
      addr_q     <= 32'd0;
      count_q    <= 16'd0;
      timer_q    <= 16'd0;
      ready_q    <= 1'b0;
      cyc_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != WRITE);
      done_q  <= (hdr_last && (hdr_count == 16'd0)) || (ack_hit && last_word);
      err_q   <= time_out;

      if (accept) begin
        shift_q    <= {shift_q[15:0], byte_i};
        byte_cnt_q <= (hdr_last || data_last) ? 3'd0 : byte_cnt_q + 3'd1;
      end

      if ((state_q == HDR) && accept && (byte_cnt_q == 3'd3))
        addr_q <= {shift_q, byte_i[7:2], 2'b00};

      if (hdr_last)
        count_q <= hdr_count;

      if (data_last) begin
        cyc_q   <= 1'b1;
        adr_q   <= addr_q;
        dat_q   <= {shift_q, byte_i};
        timer_q <= 16'd0;
      end

      if (state_q == WRITE) begin
        if (ack_hit) begin
          cyc_q   <= 1'b0;
          addr_q  <= addr_q + 32'd4;
          count_q <= count_q - 16'd1;
        end else if (time_out) begin
          cyc_q <= 1'b0;
        end else begin
          timer_q <= timer_q + 16'd1;
        end
      end
    end
  end

  assign byte_ready_o = ready_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = cyc_q;
  assign wb_sel_o     = {4{cyc_q}};
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign busy_o       = (state_q != HDR) || (byte_cnt_q != 3'd0);
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_wb_stream_loader.sv
// Directed bench for wb_stream_loader: drives byte streams against a
// BlockRAM-like slave (ack one cycle after strobe) and checks bus activity.
module tb_wb_stream_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  byte_i = 8'd0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic        busy_o, done_o, err_o;

  logic        ack_en = 1'b1;
  int          tests = 0;
  int          fails = 0;
  int          stb_cycles, done_cnt, err_cnt, overlap_cnt, wr_n;
  logic [31:0] wr_adr [8];
  logic [31:0] wr_dat [8];
  logic [3:0]  wr_sel [8];

  wb_stream_loader #(.timeout_cycles(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // BlockRAM-style slave: ack one cycle after strobe, toggling while held.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wb_ack_i <= 1'b0;
    else       wb_ack_i <= ack_en && wb_stb_o && !wb_ack_i;
  end

  always @(negedge clk_i) begin
    if (wb_stb_o) stb_cycles++;
    if (wb_stb_o && byte_ready_o) overlap_cnt++;
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
    if (wb_stb_o && wb_ack_i) begin
      if (wr_n < 8) begin
        wr_adr[wr_n] = wb_adr_o;
        wr_dat[wr_n] = wb_dat_o;
        wr_sel[wr_n] = wb_sel_o;
      end
      wr_n++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearStats();
    stb_cycles = 0; done_cnt = 0; err_cnt = 0; overlap_cnt = 0; wr_n = 0;
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) checkOutput("ready_wait", 32'd0, 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic sendBytes(input logic [7:0] bytes [$]);
    foreach (bytes[i]) applyStimulus(bytes[i]);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busy_o || wb_cyc_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) checkOutput("idle_wait", 32'd0, 32'd1);
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    clearStats();
    repeat (2) @(negedge clk_i);
    checkOutput("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    checkOutput("rst_cyc",   {31'd0, wb_cyc_o}, 32'd0);
    checkOutput("rst_sel",   {28'd0, wb_sel_o}, 32'd0);
    checkOutput("rst_adr",   wb_adr_o, 32'd0);
    checkOutput("rst_dat",   wb_dat_o, 32'd0);
    checkOutput("rst_busy",  {31'd0, busy_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("ready_after_rst", {31'd0, byte_ready_o}, 32'd1);

    // Single word
    clearStats();
    sendBytes('{8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
    waitIdle();
    checkOutput("t1_writes", wr_n, 32'd1);
    checkOutput("t1_adr", wr_adr[0], 32'h0000_1000);
    checkOutput("t1_dat", wr_dat[0], 32'hDEAD_BEEF);
    checkOutput("t1_sel", {28'd0, wr_sel[0]}, 32'hF);
    checkOutput("t1_done", done_cnt, 32'd1);
    checkOutput("t1_stb_cycles", stb_cycles, 32'd2);
    checkOutput("t1_err", err_cnt, 32'd0);

    // Three words, unaligned start address
    clearStats();
    sendBytes('{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h03,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                8'h09, 8'h0A, 8'h0B, 8'h0C});
    waitIdle();
    checkOutput("t2_writes", wr_n, 32'd3);
    checkOutput("t2_adr0", wr_adr[0], 32'h0000_0000);
    checkOutput("t2_adr1", wr_adr[1], 32'h0000_0004);
    checkOutput("t2_adr2", wr_adr[2], 32'h0000_0008);
    checkOutput("t2_dat0", wr_dat[0], 32'h0102_0304);
    checkOutput("t2_dat2", wr_dat[2], 32'h090A_0B0C);
    checkOutput("t2_done", done_cnt, 32'd1);
    checkOutput("t2_ready_vs_stb", overlap_cnt, 32'd0);

    // Zero-length transfer
    clearStats();
    sendBytes('{8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00});
    waitIdle();
    checkOutput("t3_done", done_cnt, 32'd1);
    checkOutput("t3_stb_cycles", stb_cycles, 32'd0);

    // Slave never acks
    clearStats();
    ack_en = 1'b0;
    sendBytes('{8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    waitIdle();
    checkOutput("t4_stb_cycles", stb_cycles, 32'd8);
    checkOutput("t4_err", err_cnt, 32'd1);
    checkOutput("t4_done", done_cnt, 32'd0);
    checkOutput("t4_writes", wr_n, 32'd0);
    clearStats();
    ack_en = 1'b1;
    sendBytes('{8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44});
    waitIdle();
    checkOutput("t4_new_hdr_adr", wr_adr[0], 32'h0000_3000);
    checkOutput("t4_new_hdr_dat", wr_dat[0], 32'h1122_3344);
    checkOutput("t4_new_hdr_done", done_cnt, 32'd1);

    // Reset while a write is outstanding
    ack_en = 1'b0;
    sendBytes('{8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88});
    @(negedge clk_i);
    checkOutput("t5_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("t5_cyc_rst", {31'd0, wb_cyc_o}, 32'd0);
    checkOutput("t5_stb_rst", {31'd0, wb_stb_o}, 32'd0);
    checkOutput("t5_sel_rst", {28'd0, wb_sel_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    ack_en = 1'b1;
    @(negedge clk_i);
    clearStats();
    sendBytes('{8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE});
    waitIdle();
    checkOutput("t5_writes", wr_n, 32'd1);
    checkOutput("t5_adr", wr_adr[0], 32'h0000_0040);
    checkOutput("t5_dat", wr_dat[0], 32'hCAFE_BABE);
    checkOutput("t5_done", done_cnt, 32'd1);

    // Address wraps past 2^32
    clearStats();
    sendBytes('{8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h00, 8'h02,
                8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0});
    waitIdle();
    checkOutput("t6_writes", wr_n, 32'd2);
    checkOutput("t6_adr0", wr_adr[0], 32'hFFFF_FFFC);
    checkOutput("t6_adr1", wr_adr[1], 32'h0000_0000);
    checkOutput("t6_dat1", wr_dat[1], 32'h9ABC_DEF0);
    checkOutput("t6_done", done_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
